// File: rtl/game_pkg.sv
// Shared game types: overlay codes, flow states and level index width.
// Pure declarations; no logic, no latency, no backpressure.
package game_pkg;

  localparam int LEVEL_W = 2;

  typedef enum logic [2:0] {
    SCR_TITLE     = 3'd0,
    SCR_PLAY      = 3'd1,
    SCR_CLEAR     = 3'd2,
    SCR_DEAD      = 3'd3,
    SCR_GAME_OVER = 3'd4,
    SCR_VICTORY   = 3'd5
  } screen_t;

  typedef enum logic [2:0] {
    ST_TITLE,
    ST_LOAD,
    ST_PLAY,
    ST_CLEAR_HOLD,
    ST_DEAD_HOLD,
    ST_GAME_OVER,
    ST_VICTORY
  } flow_state_t;

  function automatic screen_t screen_of(input flow_state_t st);
    screen_t scr;
    unique case (st)
      ST_LOAD, ST_PLAY: scr = SCR_PLAY;
      ST_CLEAR_HOLD:    scr = SCR_CLEAR;
      ST_DEAD_HOLD:     scr = SCR_DEAD;
      ST_GAME_OVER:     scr = SCR_GAME_OVER;
      ST_VICTORY:       scr = SCR_VICTORY;
      default:          scr = SCR_TITLE;
    endcase
    return scr;
  endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Bundle between the flow controller and the level/renderer side.
// Wires only; master is the controller, slave is the level/renderer side.
interface game_flow_controller_if;
  import game_pkg::*;

  logic               start_button;
  logic               level_win;
  logic               level_lose;
  logic [LEVEL_W-1:0] level_select;
  logic               level_reset;
  screen_t            screen;
  logic [1:0]         lives;

  modport master (
    input  start_button, level_win, level_lose,
    output level_select, level_reset, screen, lives
  );

  modport slave (
    output start_button, level_win, level_lose,
    input  level_select, level_reset, screen, lives
  );

endinterface

// File: rtl/button_edge.sv
// Two-flop synchroniser plus rising-edge detect for an async push button.
// Pulse is valid after the 2nd edge following the rise; one pulse per press, no backpressure.
module button_edge (
  input  logic vga_clock,
  input  logic reset,
  input  logic button,
  output logic pulse
);

  logic sync_1;
  logic sync_2;
  logic prev;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync_1 <= button;
      sync_2 <= sync_1;
      prev   <= sync_2;
    end
  end

  assign pulse = sync_2 & ~prev;

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: title/load/play/clear/dead/game-over/victory; all outputs registered, state moves one edge after its cause.
// Optional lives tracking under GAME_FLOW_LIVES_EN; no backpressure, level_win/level_lose sampled only in PLAY.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int NUM_LEVELS   = 3,
  parameter int MAX_LIVES    = 3,
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int RESET_CYCLES = 4
) (
  input  logic                   vga_clock,
  input  logic                   reset,
  game_flow_controller_if.master flow
);

  flow_state_t        state;
  flow_state_t        state_nxt;
  logic [31:0]        hold_cnt;
  logic [LEVEL_W-1:0] level_sel_q;
  logic [1:0]         lives_q;
  screen_t            screen_q;
  screen_t            screen_nxt;
  logic               level_reset_q;
  logic               level_reset_nxt;
  logic               start_pulse;
  logic               load_done;
  logic               hold_done;
  logic               last_level;
  logic               last_life;
  logic               timed_state;

  button_edge u_start_edge (
    .vga_clock (vga_clock),
    .reset     (reset),
    .button    (flow.start_button),
    .pulse     (start_pulse)
  );

  assign load_done   = (hold_cnt == 32'(RESET_CYCLES - 1));
  assign hold_done   = (hold_cnt == 32'(HOLD_CYCLES - 1));
  assign last_level  = (level_sel_q == LEVEL_W'(NUM_LEVELS - 1));
  assign timed_state = (state == ST_LOAD) || (state == ST_CLEAR_HOLD) || (state == ST_DEAD_HOLD);

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_TITLE;
      screen_q      <= SCR_TITLE;
      level_reset_q <= 1'b0;
      hold_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      screen_q      <= screen_nxt;
      level_reset_q <= level_reset_nxt;
      // every state change restarts the count, so LOAD and both holds start at zero
      if (state_nxt != state) begin
        hold_cnt <= '0;
      end else if (timed_state) begin
        hold_cnt <= hold_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_TITLE:      if (start_pulse) state_nxt = ST_LOAD;
      ST_LOAD:       if (load_done) state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (flow.level_win) begin
          state_nxt = ST_CLEAR_HOLD;
        end else if (flow.level_lose) begin
          state_nxt = ST_DEAD_HOLD;
        end
      end
      ST_CLEAR_HOLD: if (hold_done) state_nxt = last_level ? ST_VICTORY : ST_LOAD;
      ST_DEAD_HOLD:  if (hold_done) state_nxt = last_life ? ST_GAME_OVER : ST_LOAD;
      ST_GAME_OVER,
      ST_VICTORY:    if (start_pulse) state_nxt = ST_TITLE;
      default:       state_nxt = ST_TITLE;
    endcase
  end

  // outputs are decoded from the next state so the registered copies track the state register
  always_comb begin
    screen_nxt      = screen_of(state_nxt);
    level_reset_nxt = (state_nxt == ST_PLAY);
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      level_sel_q <= '0;
    end else if ((state == ST_TITLE) && start_pulse) begin
      level_sel_q <= '0;
    end else if ((state == ST_CLEAR_HOLD) && hold_done && !last_level) begin
      level_sel_q <= level_sel_q + LEVEL_W'(1);
    end
  end

`ifdef GAME_FLOW_LIVES_EN
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      lives_q <= 2'(MAX_LIVES);
    end else if ((state == ST_TITLE) && start_pulse) begin
      lives_q <= 2'(MAX_LIVES);
    end else if ((state == ST_DEAD_HOLD) && hold_done) begin
      lives_q <= lives_q - 2'd1;
    end
  end

  assign last_life = (lives_q == 2'd1);
`else
  // a single life, never more than MAX_LIVES allows
  assign lives_q   = 2'((MAX_LIVES < 1) ? MAX_LIVES : 1);
  assign last_life = 1'b1;
`endif

  assign flow.level_select = level_sel_q;
  assign flow.level_reset  = level_reset_q;
  assign flow.screen       = screen_q;
  assign flow.lives        = lives_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: per-cycle expected timeline built from game phases, with random lengths and ignored-input noise.
// Works with or without GAME_FLOW_LIVES_EN defined.
module tb_game_flow_controller;
  import game_pkg::*;

  localparam int HOLD = 8;
  localparam int RST  = 4;
  localparam int NLEV = 3;
  localparam int MAXL = 3;
`ifdef GAME_FLOW_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif
  localparam int START_LIVES = LIVES_EN ? MAXL : 1;

  logic vga_clock = 1'b0;
  logic reset     = 1'b0;

  game_flow_controller_if bus ();

  game_flow_controller #(
    .NUM_LEVELS   (NLEV),
    .MAX_LIVES    (MAXL),
    .HOLD_CYCLES  (HOLD),
    .RESET_CYCLES (RST)
  ) dut (
    .vga_clock (vga_clock),
    .reset     (reset),
    .flow      (bus)
  );

  always #5 vga_clock = ~vga_clock;

  // one entry per clock: inputs driven before the edge, outputs expected after it
  typedef struct {
    bit start;
    bit win;
    bit lose;
    int scr;
    bit lr;
    int sel;
    int lv;
  } step_t;

  step_t plan[$];
  int    n_assert  = 0;
  int    n_fail    = 0;
  int    step_idx  = 0;
  int    m_scr     = 0;
  int    m_sel     = 0;
  int    m_lives   = START_LIVES;
  int    start_rem = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int scr, input bit lr, input int sel, input int lv);
    chk({tag, " screen"}, 32'(bus.screen), 32'(scr));
    chk({tag, " level_reset"}, 32'(bus.level_reset), 32'(lr));
    chk({tag, " level_select"}, 32'(bus.level_select), 32'(sel));
    chk({tag, " lives"}, 32'(bus.lives), 32'(lv));
  endtask

  task automatic add(input bit win, input bit lose, input int scr, input bit lr, input int n,
                     input bit wl_noise, input bit st_noise);
    for (int i = 0; i < n; i++) begin
      step_t s;
      s.start = (start_rem > 0) || (st_noise && ($urandom_range(0, 5) == 0));
      if (start_rem > 0) start_rem--;
      s.win  = win  || (wl_noise && ($urandom_range(0, 3) == 0));
      s.lose = lose || (wl_noise && ($urandom_range(0, 3) == 0));
      s.scr  = scr;
      s.lr   = lr;
      s.sel  = m_sel;
      s.lv   = m_lives;
      plan.push_back(s);
    end
  endtask

  task automatic ph_idle(input int scr, input int n);
    m_scr = scr;
    add(1'b0, 1'b0, scr, 1'b0, n, 1'b1, 1'b0);
  endtask

  task automatic ph_load();
    m_scr = 1;
    add(1'b0, 1'b0, 1, 1'b0, RST, 1'b1, 1'b0);
  endtask

  task automatic ph_play(input int n);
    add(1'b0, 1'b0, 1, 1'b1, n, 1'b0, 1'b1);
  endtask

  // the edge that samples win/lose enters the hold; the hold shows for HOLD cycles in total
  task automatic ph_outcome(input bit w, input bit l);
    if (w) begin
      add(1'b1, l, 2, 1'b0, 1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 2, 1'b0, HOLD - 1, 1'b1, 1'b0);
      if (m_sel == NLEV - 1) begin
        ph_idle(5, $urandom_range(3, 6));
      end else begin
        m_sel++;
        ph_load();
      end
    end else begin
      add(1'b0, 1'b1, 3, 1'b0, 1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 3, 1'b0, HOLD - 1, 1'b1, 1'b0);
      if (!LIVES_EN || m_lives == 1) begin
        m_lives = LIVES_EN ? 0 : 1;
        ph_idle(4, $urandom_range(3, 6));
      end else begin
        m_lives--;
        ph_load();
      end
    end
  endtask

  // start must be seen low before the press; the state moves on the 3rd edge after the rise
  task automatic ph_press(input int len);
    while (start_rem > 0) add(1'b0, 1'b0, m_scr, 1'b0, 1, 1'b1, 1'b0);
    add(1'b0, 1'b0, m_scr, 1'b0, 1, 1'b1, 1'b0);
    start_rem = len;
    add(1'b0, 1'b0, m_scr, 1'b0, 2, 1'b1, 1'b0);
    if (m_scr == 0) begin
      m_sel   = 0;
      m_lives = START_LIVES;
      ph_load();
    end else begin
      ph_idle(0, $urandom_range(3, 5));
    end
  endtask

  task automatic run();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      bus.start_button = s.start;
      bus.level_win    = s.win;
      bus.level_lose   = s.lose;
      @(posedge vga_clock);
      #1;
      step_idx++;
      chk_all($sformatf("step%0d", step_idx), s.scr, s.lr, s.sel, s.lv);
    end
  endtask

  initial begin
    bus.start_button = 1'b0;
    bus.level_win    = 1'b0;
    bus.level_lose   = 1'b0;
    reset            = 1'b0;

    #12;
    chk_all("reset", 0, 1'b0, 0, START_LIVES);
    @(posedge vga_clock);
    #1;
    reset = 1'b1;

    // long press into a full three-level run ending in victory, then back to title
    ph_idle(0, 3);
    ph_press(20);
    for (int lvl = 0; lvl < NLEV; lvl++) begin
      ph_play($urandom_range(1, 6));
      ph_outcome(1'b1, 1'b0);
    end
    ph_press($urandom_range(1, 4));
    run();

    // clear level 0, then lose on level 1 until game over, then back to title
    ph_press($urandom_range(1, 4));
    ph_play($urandom_range(1, 6));
    ph_outcome(1'b1, 1'b0);
    while (m_scr != 4) begin
      ph_play($urandom_range(1, 6));
      ph_outcome(1'b0, 1'b1);
    end
    ph_press($urandom_range(1, 4));
    run();

    // simultaneous win and lose, then a loss interrupted by reset at hold count 5
    ph_press($urandom_range(1, 4));
    ph_play($urandom_range(1, 6));
    ph_outcome(1'b1, 1'b1);
    ph_play($urandom_range(1, 6));
    add(1'b0, 1'b1, 3, 1'b0, 1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 3, 1'b0, 5, 1'b1, 1'b0);
    run();
    #2;
    reset = 1'b0;
    #1;
    chk_all("reset_mid_hold", 0, 1'b0, 0, START_LIVES);
    @(posedge vga_clock);
    #1;
    chk_all("reset_held", 0, 1'b0, 0, START_LIVES);
    bus.start_button = 1'b0;
    bus.level_win    = 1'b0;
    bus.level_lose   = 1'b0;
    reset            = 1'b1;
    m_scr     = 0;
    m_sel     = 0;
    m_lives   = START_LIVES;
    start_rem = 0;
    ph_idle(0, 2);
    ph_press($urandom_range(1, 4));
    ph_play($urandom_range(2, 6));
    run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Top-level game sequencer that owns the active level's reset and selection. Walks the player through title, play, level-clear, death, game-over and victory. Consumes `win`/`lose` from the currently selected level instance and drives that instance's active-low `reset`, so a level only runs while being played. It also selects which level's `background`/sprite outputs the renderer shows, and tells the renderer which full-screen overlay to draw.

## Interface
- `NUM_LEVELS`, default 3: number of levels; legal range 1..4.
- `MAX_LIVES`, default 3: lives at game start; legal range 1..3.
- `HOLD_CYCLES`, default 50_000_000: duration of the clear and death screens (2 s at 25 MHz `vga_clock`); must be ≥1.
- `RESET_CYCLES`, default 4: length of the level reset pulse on every (re)load; must be ≥1.
- `vga_clock`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-low; returns the block to TITLE.
- `start_button`, in, 1: asynchronous, active-high; synchronised and rising-edge detected internally.
- `level_win`, in, 1: `win` of the selected level.
- `level_lose`, in, 1: `lose` of the selected level.
- `level_select`, out, 2: index of the active level.
- `level_reset`, out, 1: active-low reset to all level instances; high only in PLAY.
- `screen`, out, 3: `screen_t` overlay code.
- `lives`, out, 2: remaining lives.

## Operation
- States: TITLE, LOAD, PLAY, CLEAR_HOLD, DEAD_HOLD, GAME_OVER, VICTORY.
- TITLE, on start pulse: go to LOAD, with `level_select`=0 and `lives`=MAX_LIVES.
- LOAD: lasts exactly RESET_CYCLES cycles, then goes to PLAY.
- PLAY, `level_win`=1: go to CLEAR_HOLD.
- PLAY, `level_lose`=1 with `level_win`=0: go to DEAD_HOLD.
- PLAY, `level_win` and `level_lose` both 1 in the same cycle: win has priority.
- `level_win`/`level_lose` are ignored outside PLAY.
- CLEAR_HOLD, after HOLD_CYCLES cycles:
  - last level (`level_select`==NUM_LEVELS-1): go to VICTORY;
  - otherwise: `level_select`+1, go to LOAD.
- DEAD_HOLD, after HOLD_CYCLES cycles:
  - `lives`==1: go to GAME_OVER, with `lives`=0;
  - otherwise: `lives`-1, go to LOAD on the same level.
- GAME_OVER / VICTORY, on start pulse: go to TITLE.
- Start pulses in LOAD, PLAY and the hold states are discarded.
- Holding `start_button` high produces exactly one pulse.
- Screen codes per state: TITLE→SCR_TITLE; LOAD and PLAY→SCR_PLAY; CLEAR_HOLD→SCR_CLEAR; DEAD_HOLD→SCR_DEAD; GAME_OVER→SCR_GAME_OVER; VICTORY→SCR_VICTORY.
- `level_reset` is low in every state except PLAY. This freezes the level's timer, goombas and coins and rebuilds its background on the next load.
- Hold counter: 32-bit, cleared on entry to LOAD or a hold state, incremented each cycle. The state exits on the cycle where count==N-1.

## Timing
- Reset values: state=TITLE, `level_select`=0, `level_reset`=0, `screen`=SCR_TITLE, `lives`=MAX_LIVES, hold counter=0, synchroniser flops=0.
- All outputs are registered. None is a combinational function of the inputs.
- Start path: 2-flop synchroniser plus a previous-value flop. The state changes on the 3rd rising edge after `start_button` rises.
- `level_win`/`level_lose` are sampled in PLAY; the state leaves PLAY on the next edge. `level_reset` falls on that same edge.
- LOAD holds `level_reset` low for exactly RESET_CYCLES cycles. `level_reset` rises with entry to PLAY.
- Reset mid-operation (any state, including mid-hold): immediate return to reset values. Counter and lives are discarded.

## Configuration
- `GAME_FLOW_LIVES_EN`, defined: lives behave as described.
- Not defined:
  - `lives` is tied to 1;
  - DEAD_HOLD always exits to GAME_OVER;
  - lives registers and decrement logic are not generated.

## Structure
- Shared package `game_pkg` holds:
  - `screen_t` enum, 3-bit: SCR_TITLE=0, SCR_PLAY=1, SCR_CLEAR=2, SCR_DEAD=3, SCR_GAME_OVER=4, SCR_VICTORY=5;
  - `flow_state_t` enum;
  - `LEVEL_W`=2.
- One sub-module, `button_edge`: synchroniser plus rising-edge pulse. Reusable for `jump_button`.
- The state register, hold counter and lives/level counters stay in `game_flow_controller`.

## Test plan
Params for all scenarios: HOLD_CYCLES=8, RESET_CYCLES=4, NUM_LEVELS=3, MAX_LIVES=3.
- Reset, then `start_button` high for 20 cycles: one LOAD entry on the 3rd edge; `level_reset` low 4 cycles then high; `screen`=1, `level_select`=0, `lives`=3; no second LOAD.
- Win pulse in PLAY on each level: CLEAR_HOLD for 8 cycles with `screen`=2. `level_select` goes 0→1→2; after the third win the block reaches VICTORY (`screen`=5).
- Three lose pulses on level 1: `lives` 3→2→1, each followed by a LOAD with `level_select`=1. The third loss gives GAME_OVER with `lives`=0, `screen`=4. A start pulse then returns to TITLE.
- `level_win`=`level_lose`=1 in the same PLAY cycle: CLEAR_HOLD entered, `lives` unchanged at 3.
- `reset` low at hold count 5 in DEAD_HOLD: outputs immediately at reset values; a later start gives a normal LOAD with `lives`=3.
- Without `GAME_FLOW_LIVES_EN`: the first lose gives GAME_OVER after 8 hold cycles; `lives` reads 1 throughout.
